// File: rtl/imu_filter_pkg.sv
// Shared constants and state encoding for the IMU axis moving-average filter.
// Optional drop counter is enabled by defining IMU_FILT_DROPCNT_EN.
package imu_filter_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_CH     = 3;
  localparam int WIN_LOG2   = 2;
  localparam int WIN        = 1 << WIN_LOG2;
  localparam int ACC_WIDTH  = DATA_WIDTH + WIN_LOG2;

  localparam int AX_X = 0;
  localparam int AX_Y = 1;
  localparam int AX_Z = 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/imu_axis_filter_scheduler_avg_update_unit.sv
// Combinational running-sum step: drop the oldest sample, add the newest,
// and scale the window sum back to sample width (floor division).
module avg_update_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LOG2   = 2,
  parameter int ACC_WIDTH  = DATA_WIDTH + WIN_LOG2
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [DATA_WIDTH-1:0] oldest,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [ACC_WIDTH-1:0]  acc_new,
  output logic signed [DATA_WIDTH-1:0] res
);

  always_comb begin
    acc_new = acc - ACC_WIDTH'(oldest) + ACC_WIDTH'(sample);
    res     = DATA_WIDTH'(acc_new >>> WIN_LOG2);
  end

endmodule

// File: rtl/imu_axis_filter_scheduler.sv
// One shared 4-tap moving-average datapath sequenced over the X/Y/Z axes.
// Define IMU_FILT_DROPCNT_EN to add the o_drop_cnt dropped-request counter.
module imu_axis_filter_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 3,
  parameter int WIN_LOG2   = 2
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_dataval,
  input  logic signed [DATA_WIDTH-1:0] i_x,
  input  logic signed [DATA_WIDTH-1:0] i_y,
  input  logic signed [DATA_WIDTH-1:0] i_z,
  output logic                         o_busy,
  output logic signed [DATA_WIDTH-1:0] o_x,
  output logic signed [DATA_WIDTH-1:0] o_y,
  output logic signed [DATA_WIDTH-1:0] o_z,
  output logic                         o_valid,
  output logic                         o_overrun
`ifdef IMU_FILT_DROPCNT_EN
  ,
  output logic [7:0]                   o_drop_cnt
`endif
);

  import imu_filter_pkg::*;

  localparam int WN   = 1 << WIN_LOG2;
  localparam int AW   = DATA_WIDTH + WIN_LOG2;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [2:0] FILL_MAX = 3'(WN);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_t state;
  state_t state_nxt;

  logic [CH_W-1:0]              ch;
  logic [2:0]                   fill;
  logic signed [DATA_WIDTH-1:0] stage [NUM_CH];
  logic signed [DATA_WIDTH-1:0] hist  [NUM_CH][WN];
  logic signed [AW-1:0]         acc   [NUM_CH];
  logic signed [DATA_WIDTH-1:0] res   [NUM_CH];

  logic signed [AW-1:0]         acc_new;
  logic signed [DATA_WIDTH-1:0] res_new;

  logic accept;
  logic drop;
  logic last;

  assign accept = (state == IDLE) && i_dataval;
  assign drop   = (state != IDLE) && i_dataval;
  assign last   = (ch == CH_LAST);
  assign o_busy = (state != IDLE);

  avg_update_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIN_LOG2   (WIN_LOG2),
    .ACC_WIDTH  (AW)
  ) u_avg (
    .acc     (acc[ch]),
    .oldest  (hist[ch][WN-1]),
    .sample  (stage[ch]),
    .acc_new (acc_new),
    .res     (res_new)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_dataval) state_nxt = CALC;
      CALC: if (last)      state_nxt = DONE;
      DONE:                state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      ch        <= '0;
      fill      <= '0;
      o_x       <= '0;
      o_y       <= '0;
      o_z       <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        stage[c] <= '0;
        acc[c]   <= '0;
        res[c]   <= '0;
        for (int k = 0; k < WN; k++) hist[c][k] <= '0;
      end
    end else begin
      o_valid <= 1'b0;
      if (accept) begin
        stage[AX_X] <= i_x;
        stage[AX_Y] <= i_y;
        stage[AX_Z] <= i_z;
        if (fill != FILL_MAX) fill <= fill + 3'd1;
      end
      if (state == CALC) begin
        acc[ch] <= acc_new;
        res[ch] <= res_new;
        for (int k = WN - 1; k > 0; k--) hist[ch][k] <= hist[ch][k-1];
        hist[ch][0] <= stage[ch];
        if (last) begin
          ch <= '0;
          // Z is the last axis, so its result is taken straight off the datapath
          if (fill == FILL_MAX) begin
            o_valid <= 1'b1;
            o_x     <= res[AX_X];
            o_y     <= res[AX_Y];
            o_z     <= res_new;
          end
        end else begin
          ch <= ch + CH_W'(1);
        end
      end
      if (drop) o_overrun <= 1'b1;
    end
  end

`ifdef IMU_FILT_DROPCNT_EN
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                           o_drop_cnt <= '0;
    else if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
  end
`endif

endmodule
